// File: rtl/wb_pkg.sv
// Shared definitions for the writeback stage: widths, participation (ppp)
// encodings, the ppp legality check and the write-request record.
package wb_pkg;

    localparam int WB_DATA_W   = 64;
    localparam int WB_ADDR_W   = 5;
    localparam int WB_LQ_DEPTH = 4;

    localparam logic [2:0] PPP_DW = 3'b000;
    localparam logic [2:0] PPP_UW = 3'b001;
    localparam logic [2:0] PPP_LW = 3'b010;
    localparam logic [2:0] PPP_UB = 3'b011;
    localparam logic [2:0] PPP_LB = 3'b100;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] rd;
        logic [2:0]           ppp;
        logic [WB_DATA_W-1:0] data;
    } wb_req_t;

    function automatic logic ppp_legal(input logic [2:0] ppp);
        return (ppp == PPP_DW) || (ppp == PPP_UW) || (ppp == PPP_LW) ||
               (ppp == PPP_UB) || (ppp == PPP_LB);
    endfunction

endpackage

// File: rtl/lq_fifo.sv
// Pending-load queue: in-order FIFO of {rd, ppp} with full/empty flags and a
// per-register busy mask built from the occupied slots.
module lq_fifo #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [ADDR_W-1:0]        push_rd,
    input  logic [2:0]               push_ppp,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [ADDR_W-1:0]        head_rd,
    output logic [2:0]               head_ppp,
    output logic [(1<<ADDR_W)-1:0]   busy_mask
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [ADDR_W-1:0] rd_mem  [DEPTH];
    logic [2:0]        ppp_mem [DEPTH];
    logic [DEPTH-1:0]  slot_vld;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    // Per-slot valid bits make full/empty and the busy mask pure functions of
    // registered state, so lq_ready never depends on this cycle's inputs.
    assign full     = &slot_vld;
    assign empty    = ~|slot_vld;
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign head_rd  = rd_mem[rd_ptr];
    assign head_ppp = ppp_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_vld <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            if (do_push) begin
                slot_vld[wr_ptr] <= 1'b1;
                wr_ptr           <= PTR_W'(wr_ptr + 1'b1);
            end
            if (do_pop) begin
                slot_vld[rd_ptr] <= 1'b0;
                rd_ptr           <= PTR_W'(rd_ptr + 1'b1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            rd_mem[wr_ptr]  <= push_rd;
            ppp_mem[wr_ptr] <= push_ppp;
        end
    end

    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_vld[i]) begin
                busy_mask[rd_mem[i]] = 1'b1;
            end
        end
        busy_mask[0] = 1'b0;
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: arbitrates load returns and ALU results onto the single
// register-file write port, holding one ALU result when a load wins.
module wb_stage
    import wb_pkg::*;
#(
    parameter int DATA_W   = WB_DATA_W,
    parameter int ADDR_W   = WB_ADDR_W,
    parameter int LQ_DEPTH = WB_LQ_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [2:0]        alu_ppp,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              ld_issue,
    input  logic [ADDR_W-1:0] ld_rd,
    input  logic [2:0]        ld_ppp,
    output logic              lq_ready,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wb_en,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic [2:0]        wb_ppp,
    output logic [31:0]       busy_mask,
    output logic [2:0]        err
);

    logic              lq_full;
    logic              lq_empty;
    logic              lq_push;
    logic              lq_pop;
    logic [ADDR_W-1:0] head_rd;
    logic [2:0]        head_ppp;

    logic              hold_valid;
    wb_req_t           hold_req;
    wb_req_t           alu_req;
    logic              alu_acc;

    logic              grant_valid;
    wb_req_t           grant_req;
    logic              hold_load;
    logic              hold_clear;
    logic              grant_legal;
    logic              write_ok;

    assign lq_ready  = !lq_full;
    assign alu_ready = !hold_valid;
    assign lq_push   = ld_issue && !lq_full;
    assign lq_pop    = mem_rvalid && !lq_empty;
    assign alu_acc   = alu_valid && !hold_valid;
    assign alu_req   = '{rd: alu_rd, ppp: alu_ppp, data: alu_data};

    lq_fifo #(
        .DEPTH  (LQ_DEPTH),
        .ADDR_W (ADDR_W)
    ) u_lq (
        .clk       (clk),
        .reset     (reset),
        .push      (lq_push),
        .push_rd   (ld_rd),
        .push_ppp  (ld_ppp),
        .pop       (lq_pop),
        .full      (lq_full),
        .empty     (lq_empty),
        .head_rd   (head_rd),
        .head_ppp  (head_ppp),
        .busy_mask (busy_mask)
    );

    // Load return > held ALU > new ALU. A new ALU result can only be
    // accepted while the hold register is empty, so it never overwrites it.
    always_comb begin
        grant_valid = 1'b0;
        grant_req   = '0;
        hold_load   = 1'b0;
        hold_clear  = 1'b0;
        if (lq_pop) begin
            grant_valid = 1'b1;
            grant_req   = '{rd: head_rd, ppp: head_ppp, data: mem_rdata};
            hold_load   = alu_acc;
        end else if (hold_valid) begin
            grant_valid = 1'b1;
            grant_req   = hold_req;
            hold_clear  = 1'b1;
        end else if (alu_acc) begin
            grant_valid = 1'b1;
            grant_req   = alu_req;
        end
    end

    assign grant_legal = ppp_legal(grant_req.ppp);
    assign write_ok    = grant_valid && grant_legal && (grant_req.rd != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_valid <= 1'b0;
            hold_req   <= '0;
            wb_en      <= 1'b0;
            wb_addr    <= '0;
            wb_data    <= '0;
            wb_ppp     <= '0;
            err        <= '0;
        end else begin
            if (hold_load) begin
                hold_valid <= 1'b1;
                hold_req   <= alu_req;
            end else if (hold_clear) begin
                hold_valid <= 1'b0;
            end

            wb_en <= write_ok;
            if (write_ok) begin
                wb_addr <= grant_req.rd;
                wb_data <= grant_req.data;
                wb_ppp  <= grant_req.ppp;
            end

            err <= err | {ld_issue && lq_full,
                          grant_valid && !grant_legal,
                          mem_rvalid && lq_empty};
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: a queue-based reference model predicts each
// register-file write and its cycle; a monitor checks the write port.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_rd = '0;
    logic [2:0]  alu_ppp = '0;
    logic [63:0] alu_data = '0;
    logic        alu_ready;
    logic        ld_issue = 1'b0;
    logic [4:0]  ld_rd = '0;
    logic [2:0]  ld_ppp = '0;
    logic        lq_ready;
    logic        mem_rvalid = 1'b0;
    logic [63:0] mem_rdata = '0;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [63:0] wb_data;
    logic [2:0]  wb_ppp;
    logic [31:0] busy_mask;
    logic [2:0]  err;

    wb_stage dut (
        .clk        (clk),
        .reset      (reset),
        .alu_valid  (alu_valid),
        .alu_rd     (alu_rd),
        .alu_ppp    (alu_ppp),
        .alu_data   (alu_data),
        .alu_ready  (alu_ready),
        .ld_issue   (ld_issue),
        .ld_rd      (ld_rd),
        .ld_ppp     (ld_ppp),
        .lq_ready   (lq_ready),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .wb_ppp     (wb_ppp),
        .busy_mask  (busy_mask),
        .err        (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          cyc;
        logic [4:0]  rd;
        logic [2:0]  ppp;
        logic [63:0] data;
    } exp_t;

    typedef struct {
        logic [4:0] rd;
        logic [2:0] ppp;
    } ld_t;

    exp_t        exp_q[$];
    ld_t         m_lq[$];
    bit          m_hold_v = 0;
    exp_t        m_hold;
    logic [2:0]  m_err = '0;
    bit          m_known = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    function automatic logic [31:0] model_busy();
        logic [31:0] m = '0;
        foreach (m_lq[i]) m[m_lq[i].rd] = 1'b1;
        m[0] = 1'b0;
        return m;
    endfunction

    // A grant becomes a visible write one cycle later unless ppp is illegal or rd is r0.
    task automatic model_write(input logic [4:0] rd, input logic [2:0] ppp, input logic [63:0] data);
        if (ppp > 3'd4) m_err[1] = 1'b1;
        else if (rd != 5'd0) exp_q.push_back('{cyc + 1, rd, ppp, data});
    endtask

    task automatic model_step();
        bit pop, push, acc;
        pop  = mem_rvalid && (m_lq.size() > 0);
        push = ld_issue && (m_lq.size() < 4);
        acc  = alu_valid && !m_hold_v;
        if (mem_rvalid && m_lq.size() == 0) m_err[0] = 1'b1;
        if (ld_issue && m_lq.size() >= 4) m_err[2] = 1'b1;
        if (pop) begin
            model_write(m_lq[0].rd, m_lq[0].ppp, mem_rdata);
            if (acc) begin
                m_hold_v = 1;
                m_hold   = '{0, alu_rd, alu_ppp, alu_data};
            end
        end else if (m_hold_v) begin
            model_write(m_hold.rd, m_hold.ppp, m_hold.data);
            m_hold_v = 0;
        end else if (acc) begin
            model_write(alu_rd, alu_ppp, alu_data);
        end
        if (pop) void'(m_lq.pop_front());
        if (push) m_lq.push_back('{ld_rd, ld_ppp});
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_lq.delete();
        m_hold_v = 0;
        m_err    = '0;
    endtask

    task automatic check_state();
        if (!m_known) return;
        chk("alu_ready", 64'(alu_ready), 64'(!m_hold_v));
        chk("lq_ready",  64'(lq_ready),  64'(m_lq.size() < 4));
        chk("busy_mask", 64'(busy_mask), 64'(model_busy()));
        chk("err",       64'(err),       64'(m_err));
    endtask

    // Called at a falling edge with inputs already driven; returns at the next one.
    task automatic tick();
        check_state();
        if (reset) begin
            model_reset();
            m_known = 1;
        end else begin
            model_step();
        end
        @(negedge clk);
        alu_valid  = 1'b0;
        ld_issue   = 1'b0;
        mem_rvalid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic alu(input logic [4:0] rd, input logic [2:0] ppp, input logic [63:0] d);
        alu_valid = 1'b1; alu_rd = rd; alu_ppp = ppp; alu_data = d;
    endtask

    task automatic issue(input logic [4:0] rd, input logic [2:0] ppp);
        ld_issue = 1'b1; ld_rd = rd; ld_ppp = ppp;
    endtask

    task automatic resp(input logic [63:0] d);
        mem_rvalid = 1'b1; mem_rdata = d;
    endtask

    // Monitor: compares the write port against the predicted write for this cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                e = exp_q.pop_front();
                checks++;
                errors++;
                $display("FAIL missed_write: no write seen for r%0d data %h due cycle %0d", e.rd, e.data, e.cyc);
            end
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                e = exp_q.pop_front();
                chk("wb_en",   64'(wb_en),   64'(1));
                chk("wb_addr", 64'(wb_addr), 64'(e.rd));
                chk("wb_ppp",  64'(wb_ppp),  64'(e.ppp));
                chk("wb_data", wb_data,      e.data);
            end else if (m_known) begin
                chk("wb_en_idle", 64'(wb_en), 64'(0));
            end
        end
    end

    initial begin
        @(negedge clk);
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        tick();
        chk("rst_wb_addr", 64'(wb_addr), 64'(0));
        chk("rst_wb_data", wb_data,      64'(0));
        chk("rst_wb_ppp",  64'(wb_ppp),  64'(0));

        // Plain ALU write
        alu(5'd5, 3'b000, 64'hDEADBEEF_CAFEF00D);
        tick();
        idle(2);

        // Load to r7, response three cycles after issue
        issue(5'd7, 3'b011);
        tick();
        idle(2);
        chk("busy_r7", 64'(busy_mask[7]), 64'(1));
        resp(64'h1122334455667788);
        tick();
        idle(2);

        // ALU collides with a load response
        issue(5'd9, 3'b001);
        tick();
        idle(1);
        alu(5'd3, 3'b010, 64'h0123456789ABCDEF);
        resp(64'hFEDCBA9876543210);
        tick();
        chk("collide_alu_ready", 64'(alu_ready), 64'(0));
        idle(3);

        // Orphan response and illegal ppp
        resp(64'h5555);
        tick();
        alu(5'd4, 3'b110, 64'h6666);
        tick();
        idle(1);
        chk("err_011", 64'(err), 64'(3'b011));

        // Fill the queue, overflow issue, then drain
        for (int r = 1; r <= 4; r++) begin
            issue(5'(r), 3'($urandom_range(0, 4)));
            tick();
        end
        chk("full_lq_ready", 64'(lq_ready), 64'(0));
        issue(5'd5, 3'b000);
        tick();
        for (int r = 1; r <= 4; r++) begin
            resp({32'hA0A0A0A0, 32'(r)});
            tick();
        end
        idle(2);
        chk("drained_busy", 64'(busy_mask), 64'(0));

        // Load to r0, then reset with two loads pending
        issue(5'd0, 3'b000);
        tick();
        resp(64'h7777);
        tick();
        issue(5'd10, 3'b000);
        tick();
        issue(5'd11, 3'b100);
        alu(5'd12, 3'b000, 64'h1212);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_wb_en",   64'(wb_en),     64'(0));
        chk("mid_rst_wb_addr", 64'(wb_addr),   64'(0));
        chk("mid_rst_wb_data", wb_data,        64'(0));
        chk("mid_rst_busy",    64'(busy_mask), 64'(0));
        chk("mid_rst_err",     64'(err),       64'(0));
        resp(64'h8888);
        tick();
        idle(1);
        chk("post_rst_orphan", 64'(err), 64'(3'b001));

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
                continue;
            end
            if ($urandom_range(0, 1) == 1) begin
                alu(5'($urandom_range(0, 31)),
                    ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4)),
                    {$urandom, $urandom});
            end
            if ($urandom_range(0, 2) == 0) begin
                issue(5'($urandom_range(0, 31)),
                      ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4)));
            end
            if (m_lq.size() > 0 ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 29) == 0)) begin
                resp({$urandom, $urandom});
            end
            tick();
        end
        idle(4);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
